// File: rtl/spi_fifo_sequencer.sv
// spi_fifo_sequencer: TX/RX FIFOs around spi_master. Each queued TX byte
// becomes one spi_master transfer, and each received byte is pushed into
// the RX FIFO. Both FIFOs are circular buffers with a separate occupancy
// count, so "full" and "empty" can be told apart at equal pointers.
module spi_fifo_sequencer #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          flush,
    input  logic          clr_err,
    input  logic          tx_wr,
    input  logic [DW-1:0] tx_wdata,
    output logic          tx_full,
    output logic          tx_empty,
    output logic [AW:0]   tx_level,
    input  logic          rx_rd,
    output logic [DW-1:0] rx_rdata,
    output logic          rx_empty,
    output logic [AW:0]   rx_level,
    output logic          tx_ovf,
    output logic          rx_ovf,
    output logic          seq_busy,
    output logic          seq_idle_empty,
    output logic          spi_go,
    output logic [DW-1:0] spi_datai,
    input  logic          spi_done,
    input  logic [DW-1:0] spi_datao
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] tx_mem [DEPTH];
    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [AW:0]   tx_cnt_q, rx_cnt_q;
    logic [DW-1:0] spi_datai_q;
    logic          tx_ovf_q, rx_ovf_q;

    logic tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
    logic rx_full;

    assign tx_full  = (tx_cnt_q == CNT_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CNT_FULL);
    assign rx_empty = (rx_cnt_q == '0);

    // flush overrides every FIFO movement in its cycle; an ignored pop on an
    // empty FIFO and an ignored push on a full one never touch the pointers.
    assign tx_push     = tx_wr & ~tx_full & ~flush;
    assign tx_pop      = (state_q == IDLE) & enable & ~tx_empty & ~flush;
    assign rx_push_req = (state_q == WAIT) & spi_done;
    assign rx_push     = rx_push_req & ~rx_full & ~flush;
    assign rx_pop      = rx_rd & ~rx_empty & ~flush;

    // Next-state logic: one pop per transfer, one go pulse, then wait for done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_pop) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (spi_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FIFO storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= tx_wdata;
        if (rx_push) rx_mem[rx_wp_q] <= spi_datao;
    end

    // TX pointers and count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + (AW+1)'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - (AW+1)'(1);
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // RX pointers and count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + (AW+1)'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - (AW+1)'(1);
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // Outgoing byte is latched on pop and held through START and WAIT.
    always_ff @(posedge clk) begin
        if (rst)         spi_datai_q <= '0;
        else if (tx_pop) spi_datai_q <= tx_mem[tx_rp_q];
    end

    // Sticky overflow flags; a same-cycle error event beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_ovf_q <= (tx_ovf_q & ~clr_err) | (tx_wr & tx_full);
            rx_ovf_q <= (rx_ovf_q & ~clr_err) | (rx_push_req & rx_full);
        end
    end

    assign tx_level       = tx_cnt_q;
    assign rx_level       = rx_cnt_q;
    assign rx_rdata       = rx_empty ? '0 : rx_mem[rx_rp_q];
    assign tx_ovf         = tx_ovf_q;
    assign rx_ovf         = rx_ovf_q;
    assign seq_busy       = (state_q != IDLE);
    assign seq_idle_empty = (state_q == IDLE) & tx_empty;
    assign spi_go         = (state_q == START);
    assign spi_datai      = spi_datai_q;

endmodule
